// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler of NUM_CH UDP header+payload requesters onto one engine; UDP_TX_SCHED_LEN_CHECK_EN enables length rejection.
// Header registered 1 cycle after request, payload combinational; header held until m_udp_hdr_ready, owner req_tready follows m_tready.
module udp_tx_scheduler #(
  parameter int NUM_CH  = 4,
  parameter int MAX_LEN = 1472
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     req_hdr_valid,
  output logic [NUM_CH-1:0]     req_hdr_ready,
  input  logic [32*NUM_CH-1:0]  req_dest_ip,
  input  logic [32*NUM_CH-1:0]  req_ports,
  input  logic [16*NUM_CH-1:0]  req_len,
  input  logic [8*NUM_CH-1:0]   req_tdata,
  input  logic [NUM_CH-1:0]     req_tvalid,
  input  logic [NUM_CH-1:0]     req_tlast,
  output logic [NUM_CH-1:0]     req_tready,
  output logic                  m_udp_hdr_valid,
  input  logic                  m_udp_hdr_ready,
  output logic [31:0]           m_dest_ip,
  output logic [15:0]           m_src_port,
  output logic [15:0]           m_dest_port,
  output logic [15:0]           m_length,
  output logic [7:0]            m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic                  m_tuser,
  input  logic                  m_tready,
  output logic [NUM_CH-1:0]     grant,
  output logic                  busy,
  output logic                  err_len
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] dest_ip;
    logic [15:0] src_port;
    logic [15:0] dest_port;
    logic [15:0] length;
  } hdr_t;

  state_t              state;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       gidx;
  logic [NUM_CH-1:0]   grant_q;
  hdr_t                hdr_q;
  logic                hdr_vld_q;
  logic [15:0]         cnt;

  logic                any_req;
  logic                any_hi;
  logic [IW-1:0]       win_hi;
  logic [IW-1:0]       win_lo;
  logic [IW-1:0]       win;
  logic [NUM_CH-1:0]   win_onehot;
  hdr_t                win_hdr;
  logic                len_bad;
  logic                reject;

  logic [7:0]          sel_tdata;
  logic                sel_tvalid;
  logic                sel_tlast;
  logic [15:0]         cnt_inc;
  logic                at_len;
  logic                beat;

  // Two-pass round robin: lowest requester above rr_ptr, else lowest overall (wrap).
  always_comb begin
    any_hi = 1'b0;
    win_hi = '0;
    win_lo = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req_hdr_valid[i]) begin
        win_lo = IW'(i);
        if (IW'(i) > rr_ptr) begin
          any_hi = 1'b1;
          win_hi = IW'(i);
        end
      end
    end
  end

  assign any_req    = |req_hdr_valid;
  assign win        = any_hi ? win_hi : win_lo;
  assign win_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << win;

  always_comb begin
    win_hdr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win == IW'(i)) begin
        win_hdr.dest_ip   = req_dest_ip[32*i +: 32];
        win_hdr.src_port  = req_ports[32*i+16 +: 16];
        win_hdr.dest_port = req_ports[32*i +: 16];
        win_hdr.length    = req_len[16*i +: 16];
      end
    end
  end

  always_comb begin
    sel_tdata  = '0;
    sel_tvalid = 1'b0;
    sel_tlast  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (gidx == IW'(i)) begin
        sel_tdata  = req_tdata[8*i +: 8];
        sel_tvalid = req_tvalid[i];
        sel_tlast  = req_tlast[i];
      end
    end
  end

`ifdef UDP_TX_SCHED_LEN_CHECK_EN
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);
  assign len_bad = (win_hdr.length == 16'd0) || (win_hdr.length > MAX_LEN16);
  // Reject ack is combinational so the requester drops valid before re-arbitration; gated so reset stays quiet.
  assign reject  = rst && (state == IDLE) && any_req && len_bad;
  assign err_len = reject;
`else
  localparam logic [15:0] unused_max_len = 16'(MAX_LEN);
  assign len_bad = 1'b0;
  assign reject  = 1'b0;
  assign err_len = 1'b0;
`endif

  assign req_hdr_ready = (grant_q & {NUM_CH{(state == HDR) && m_udp_hdr_ready}})
                       | (win_onehot & {NUM_CH{reject}});

  assign cnt_inc  = cnt + 16'd1;
  assign at_len   = (cnt_inc == hdr_q.length);
  assign m_tvalid = (state == PAYLOAD) && sel_tvalid;
  assign m_tdata  = (state == PAYLOAD) ? sel_tdata : 8'd0;
  assign beat     = m_tvalid && m_tready;
  // A frame ends on source tlast or on the header length; disagreement between the two marks it bad.
  assign m_tlast  = m_tvalid && (sel_tlast || at_len);
  assign m_tuser  = m_tvalid && (sel_tlast != at_len);

  always_comb begin
    req_tready = '0;
    if (state == PAYLOAD)
      req_tready = grant_q & {NUM_CH{m_tready}};
    else if (state == DRAIN)
      req_tready = grant_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= IW'(NUM_CH - 1);
      gidx      <= '0;
      grant_q   <= '0;
      hdr_q     <= '0;
      hdr_vld_q <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            if (len_bad) begin
              rr_ptr <= win;
            end else begin
              state     <= HDR;
              gidx      <= win;
              grant_q   <= win_onehot;
              hdr_q     <= win_hdr;
              hdr_vld_q <= 1'b1;
            end
          end
        end
        HDR: begin
          if (m_udp_hdr_ready) begin
            hdr_vld_q <= 1'b0;
            cnt       <= '0;
            if (hdr_q.length == 16'd0) begin
              state   <= IDLE;
              rr_ptr  <= gidx;
              grant_q <= '0;
            end else begin
              state <= PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (beat) begin
            cnt <= cnt_inc;
            if (sel_tlast) begin
              state   <= IDLE;
              rr_ptr  <= gidx;
              grant_q <= '0;
            end else if (at_len) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (sel_tvalid && sel_tlast) begin
            state   <= IDLE;
            rr_ptr  <= gidx;
            grant_q <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant           = grant_q;
  assign busy            = (state != IDLE);
  assign m_udp_hdr_valid = hdr_vld_q;
  assign m_dest_ip       = hdr_q.dest_ip;
  assign m_src_port      = hdr_q.src_port;
  assign m_dest_port     = hdr_q.dest_port;
  assign m_length        = hdr_q.length;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Scoreboard bench for udp_tx_scheduler: tests push expected headers/beats, a negedge monitor pops and compares.
module tb_udp_tx_scheduler;
  localparam int NUM_CH  = 4;
  localparam int MAX_LEN = 1472;
  localparam int BUDGET  = 500;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NUM_CH-1:0]    req_hdr_valid = '0;
  logic [NUM_CH-1:0]    req_hdr_ready;
  logic [32*NUM_CH-1:0] req_dest_ip = '0;
  logic [32*NUM_CH-1:0] req_ports = '0;
  logic [16*NUM_CH-1:0] req_len = '0;
  logic [8*NUM_CH-1:0]  req_tdata = '0;
  logic [NUM_CH-1:0]    req_tvalid = '0;
  logic [NUM_CH-1:0]    req_tlast = '0;
  logic [NUM_CH-1:0]    req_tready;
  logic                 m_udp_hdr_valid;
  logic                 m_udp_hdr_ready = 1'b1;
  logic [31:0]          m_dest_ip;
  logic [15:0]          m_src_port, m_dest_port, m_length;
  logic [7:0]           m_tdata;
  logic                 m_tvalid, m_tlast, m_tuser;
  logic                 m_tready = 1'b1;
  logic [NUM_CH-1:0]    grant;
  logic                 busy;
  logic                 err_len;

  udp_tx_scheduler #(.NUM_CH(NUM_CH), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst),
    .req_hdr_valid(req_hdr_valid), .req_hdr_ready(req_hdr_ready),
    .req_dest_ip(req_dest_ip), .req_ports(req_ports), .req_len(req_len),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tlast(req_tlast),
    .req_tready(req_tready),
    .m_udp_hdr_valid(m_udp_hdr_valid), .m_udp_hdr_ready(m_udp_hdr_ready),
    .m_dest_ip(m_dest_ip), .m_src_port(m_src_port), .m_dest_port(m_dest_port),
    .m_length(m_length), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .m_tready(m_tready),
    .grant(grant), .busy(busy), .err_len(err_len)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NUM_CH-1:0] grant;
    logic [31:0]       ip;
    logic [15:0]       sp;
    logic [15:0]       dp;
    logic [15:0]       len;
  } hdr_exp_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_exp_t;

  hdr_exp_t  hdr_q[$];
  beat_exp_t beat_q[$];
  hdr_exp_t  mon_h;
  beat_exp_t mon_b;

  int  tests = 0, fails = 0;
  int  hdr_cnt = 0, beat_cnt = 0, drain_cnt = 0, err_cnt = 0, busy_cnt = 0;
  bit  abort = 1'b0;
  bit  bp_en = 1'b0;

  function automatic logic [31:0] ip_of(input int ch, input logic [7:0] seed);
    return 32'hC0A8_0000 | (32'(ch) << 8) | 32'(seed);
  endfunction

  function automatic logic [31:0] ports_of(input int ch, input logic [7:0] seed);
    return {16'h1000 + 16'(ch), 16'h2000 + 16'(seed)};
  endfunction

  function automatic logic [7:0] byte_of(input logic [7:0] seed, input int k);
    return seed + 8'(k * 17);
  endfunction

  always @(posedge clk) begin
    #1;
    m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference: a beat ends the frame on source tlast or on the header length; bad unless both coincide.
  task automatic expect_frame(input int ch, input logic [15:0] len, input int tlast_at, input logic [7:0] seed);
    hdr_exp_t  h;
    beat_exp_t b;
    bit        tl, atl;
    h.grant = NUM_CH'(1) << ch;
    h.ip    = ip_of(ch, seed);
    {h.sp, h.dp} = ports_of(ch, seed);
    h.len   = len;
    hdr_q.push_back(h);
    for (int k = 1; k <= int'(len); k++) begin
      tl  = (k == tlast_at);
      atl = (k == int'(len));
      b.data = byte_of(seed, k);
      b.last = tl || atl;
      b.user = tl ? !atl : atl;
      beat_q.push_back(b);
      if (b.last) break;
    end
  endtask

  task automatic send_frame(input int ch, input logic [15:0] len, input int nbytes,
                            input int tlast_at, input logic [7:0] seed, input bit push_exp);
    int n;
    if (push_exp) expect_frame(ch, len, tlast_at, seed);
    @(posedge clk); #1;
    req_dest_ip[32*ch +: 32] = ip_of(ch, seed);
    req_ports[32*ch +: 32]   = ports_of(ch, seed);
    req_len[16*ch +: 16]     = len;
    req_hdr_valid[ch]        = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (abort) begin req_hdr_valid[ch] = 1'b0; return; end
      if (req_hdr_ready[ch]) break;
      n++;
      if (n > BUDGET) begin
        tests++; fails++;
        $display("FAIL hdr_accept_timeout ch=%0d got no req_hdr_ready, required within %0d cycles", ch, BUDGET);
        req_hdr_valid[ch] = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    req_hdr_valid[ch] = 1'b0;
    for (int k = 1; k <= nbytes; k++) begin
      req_tdata[8*ch +: 8] = byte_of(seed, k);
      req_tvalid[ch]       = 1'b1;
      req_tlast[ch]        = (k == tlast_at);
      n = 0;
      forever begin
        @(negedge clk);
        if (abort) begin req_tvalid[ch] = 1'b0; req_tlast[ch] = 1'b0; return; end
        if (req_tready[ch]) break;
        n++;
        if (n > BUDGET) begin
          tests++; fails++;
          $display("FAIL byte_timeout ch=%0d byte=%0d got no req_tready, required within %0d cycles", ch, k, BUDGET);
          req_tvalid[ch] = 1'b0; req_tlast[ch] = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    req_tvalid[ch] = 1'b0;
    req_tlast[ch]  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    tests++;
    for (int n = 0; n < BUDGET; n++) begin
      @(negedge clk);
      if (!busy) return;
    end
    fails++;
    $display("FAIL %s idle_timeout busy=%b required 0", name, busy);
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (hdr_q.size() != 0 || beat_q.size() != 0) begin
      fails++;
      $display("FAIL %s leftover hdr=%0d beats=%0d required 0/0", name, hdr_q.size(), beat_q.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (m_udp_hdr_valid && m_udp_hdr_ready) begin
        hdr_cnt++;
        tests++;
        if (hdr_q.size() == 0) begin
          fails++;
          $display("FAIL hdr_unexpected got grant=%b len=%0d, required none", grant, m_length);
        end else begin
          mon_h = hdr_q.pop_front();
          if ({m_dest_ip, m_src_port, m_dest_port, m_length} !== {mon_h.ip, mon_h.sp, mon_h.dp, mon_h.len}) begin
            fails++;
            $display("FAIL hdr_fields got %h/%h/%h/%0d required %h/%h/%h/%0d",
                     m_dest_ip, m_src_port, m_dest_port, m_length, mon_h.ip, mon_h.sp, mon_h.dp, mon_h.len);
          end
          tests++;
          if (grant !== mon_h.grant) begin
            fails++;
            $display("FAIL hdr_grant got %b required %b", grant, mon_h.grant);
          end
        end
      end
      if (m_tvalid && m_tready) begin
        beat_cnt++;
        tests++;
        if (beat_q.size() == 0) begin
          fails++;
          $display("FAIL beat_unexpected got data=%h last=%b, required none", m_tdata, m_tlast);
        end else begin
          mon_b = beat_q.pop_front();
          if ({m_tdata, m_tlast, m_tuser} !== {mon_b.data, mon_b.last, mon_b.user}) begin
            fails++;
            $display("FAIL beat got data=%h last=%b user=%b required data=%h last=%b user=%b",
                     m_tdata, m_tlast, m_tuser, mon_b.data, mon_b.last, mon_b.user);
          end
        end
      end
      if (|(req_tvalid & req_tready) && !m_tvalid) drain_cnt++;
      if (err_len) err_cnt++;
      if (busy) busy_cnt++;
    end
  end

  task automatic test_reset();
    req_hdr_valid = 4'b0101;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b required 0", busy); end
    tests++; if (grant !== '0) begin fails++; $display("FAIL rst_grant got %b required 0", grant); end
    tests++; if (m_udp_hdr_valid !== 1'b0) begin fails++; $display("FAIL rst_hdr_valid got %b required 0", m_udp_hdr_valid); end
    tests++; if ({m_tvalid, m_tlast, m_tuser} !== 3'b000) begin fails++; $display("FAIL rst_stream got %b required 000", {m_tvalid, m_tlast, m_tuser}); end
    tests++; if ({m_dest_ip, m_src_port, m_dest_port, m_length} !== '0) begin fails++; $display("FAIL rst_hdr_fields got %h required 0", {m_dest_ip, m_src_port, m_dest_port, m_length}); end
    tests++; if (req_hdr_ready !== '0 || req_tready !== '0) begin fails++; $display("FAIL rst_readies got %b/%b required 0/0", req_hdr_ready, req_tready); end
    tests++; if (err_len !== 1'b0) begin fails++; $display("FAIL rst_err_len got %b required 0", err_len); end
    req_hdr_valid = '0;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_alternate();
    for (int f = 0; f < 2; f++) begin
      expect_frame(0, 16'd2, 2, 8'h40 + 8'(f));
      expect_frame(2, 16'd2, 2, 8'h80 + 8'(f));
    end
    bp_en = 1'b1;
    fork
      begin send_frame(0, 16'd2, 2, 2, 8'h40, 1'b0); send_frame(0, 16'd2, 2, 2, 8'h41, 1'b0); end
      begin send_frame(2, 16'd2, 2, 2, 8'h80, 1'b0); send_frame(2, 16'd2, 2, 2, 8'h81, 1'b0); end
    join
    bp_en = 1'b0;
    wait_idle("alternate");
    check_drained("alternate");
  endtask

  task automatic test_single();
    int h0;
    h0 = hdr_cnt;
    send_frame(1, 16'd4, 4, 4, 8'h00, 1'b1);
    wait_idle("single");
    tests++; if (grant !== 4'b0000) begin fails++; $display("FAIL single_grant_clear got %b required 0000", grant); end
    tests++; if (hdr_cnt - h0 != 1) begin fails++; $display("FAIL single_hdr_count got %0d required 1", hdr_cnt - h0); end
    check_drained("single");
  endtask

  task automatic test_early_tlast();
    send_frame(0, 16'd4, 2, 2, 8'hA0, 1'b1);
    wait_idle("early_tlast");
    check_drained("early_tlast");
  endtask

  task automatic test_overrun();
    int d0;
    d0 = drain_cnt;
    send_frame(0, 16'd2, 5, 5, 8'hB0, 1'b1);
    wait_idle("overrun");
    tests++; if (drain_cnt - d0 != 3) begin fails++; $display("FAIL overrun_drained got %0d required 3", drain_cnt - d0); end
    check_drained("overrun");
  endtask

`ifdef UDP_TX_SCHED_LEN_CHECK_EN
  task automatic test_len_check();
    int e0, h0, b0;
    e0 = err_cnt; h0 = hdr_cnt; b0 = busy_cnt;
    send_frame(3, 16'd1500, 0, 0, 8'h30, 1'b0);
    repeat (4) @(negedge clk);
    tests++; if (err_cnt - e0 != 1) begin fails++; $display("FAIL len_err_pulses got %0d required 1", err_cnt - e0); end
    send_frame(3, 16'd0, 0, 0, 8'h31, 1'b0);
    repeat (4) @(negedge clk);
    tests++; if (err_cnt - e0 != 2) begin fails++; $display("FAIL len0_err_pulses got %0d required 2", err_cnt - e0); end
    tests++; if (hdr_cnt != h0) begin fails++; $display("FAIL len_hdr_emitted got %0d required 0", hdr_cnt - h0); end
    tests++; if (busy_cnt != b0) begin fails++; $display("FAIL len_busy_cycles got %0d required 0", busy_cnt - b0); end
  endtask
`else
  task automatic test_zero_len();
    int b0;
    b0 = beat_cnt;
    send_frame(3, 16'd0, 0, 0, 8'h30, 1'b1);
    wait_idle("zero_len");
    tests++; if (beat_cnt != b0) begin fails++; $display("FAIL zero_len_beats got %0d required 0", beat_cnt - b0); end
    tests++; if (err_cnt != 0) begin fails++; $display("FAIL err_len_pulses got %0d required 0", err_cnt); end
    check_drained("zero_len");
  endtask
`endif

  task automatic test_hdr_stall();
    m_udp_hdr_ready = 1'b0;
    fork
      send_frame(1, 16'd2, 2, 2, 8'hC0, 1'b1);
      begin
        int n;
        n = 0;
        while (!m_udp_hdr_valid && n < BUDGET) begin @(negedge clk); n++; end
        tests++;
        if (!m_udp_hdr_valid) begin fails++; $display("FAIL stall_hdr_timeout got valid=0 required 1"); end
        for (int c = 0; c < 4; c++) begin
          @(posedge clk); #1;
          req_len[16*3 +: 16] = 16'd9;
          req_hdr_valid[3] = ~req_hdr_valid[3];
          @(negedge clk);
          tests++;
          if ({m_udp_hdr_valid, grant, m_length} !== {1'b1, 4'b0010, 16'd2}) begin
            fails++;
            $display("FAIL stall_hold got valid=%b grant=%b len=%0d required 1/0010/2", m_udp_hdr_valid, grant, m_length);
          end
          tests++;
          if (req_hdr_ready !== '0) begin fails++; $display("FAIL stall_hdr_ready got %b required 0000", req_hdr_ready); end
        end
        @(posedge clk); #1;
        req_hdr_valid[3] = 1'b0;
        m_udp_hdr_ready  = 1'b1;
      end
    join
    wait_idle("hdr_stall");
    check_drained("hdr_stall");
  endtask

  task automatic test_reset_mid();
    fork
      send_frame(2, 16'd8, 8, 8, 8'hD0, 1'b1);
      begin
        int n;
        n = 0;
        while (!(m_tvalid && m_tdata == byte_of(8'hD0, 4)) && n < BUDGET) begin @(negedge clk); n++; end
        tests++;
        if (!m_tvalid) begin fails++; $display("FAIL rstmid_beat4_timeout got m_tvalid=0 required 1"); end
        #2;
        rst = 1'b0;
        #1;
        tests++;
        if ({m_tvalid, m_tlast, m_tuser, busy, m_udp_hdr_valid} !== 5'b0) begin
          fails++;
          $display("FAIL rstmid_ctrl got %b required 00000", {m_tvalid, m_tlast, m_tuser, busy, m_udp_hdr_valid});
        end
        tests++;
        if ({grant, req_tready, m_length} !== '0) begin
          fails++;
          $display("FAIL rstmid_state got grant=%b tready=%b len=%0d required 0/0/0", grant, req_tready, m_length);
        end
        abort = 1'b1;
      end
    join
    hdr_q.delete();
    beat_q.delete();
    req_hdr_valid = '0; req_tvalid = '0; req_tlast = '0;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    expect_frame(0, 16'd2, 2, 8'hE0);
    expect_frame(1, 16'd2, 2, 8'hE1);
    fork
      send_frame(0, 16'd2, 2, 2, 8'hE0, 1'b0);
      send_frame(1, 16'd2, 2, 2, 8'hE1, 1'b0);
    join
    wait_idle("reset_mid");
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_single();
    test_early_tlast();
    test_overrun();
`ifdef UDP_TX_SCHED_LEN_CHECK_EN
    test_len_check();
`else
    test_zero_len();
`endif
    test_hdr_stall();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
